fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch initiator for the pipeline: drives the PC into the instruction memory and
//  consumes its {instr, valid} response. Captured words go into a small FIFO, tagged with their PC.
//  The FIFO decouples fetch from decode stalls. Decode pops it via a valid/ready handshake.
//  Branch/jump redirects from execute flush the FIFO and restart fetch.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC driven after reset; must be 4-byte aligned
//  FIFO_DEPTH  4              fetch-buffer entries; power of two, >= 2
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous reset, active-high
//  imem_pc         out  32  fetch address to instruction memory (registered)
//  imem_instr      in   32  instruction word from memory
//  imem_valid      in   1   imem_instr is the word at the current imem_pc
//  redirect_valid  in   1   flush and restart fetch at redirect_pc
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 0)
//  out_valid       out  1   FIFO head valid toward decode
//  out_ready       in   1   decode accepts head this cycle
//  out_instr       out  32  head instruction
//  out_pc          out  32  head PC
// BEHAVIOUR
//  Reset (async, rst=1):
//   pc=RESET_PC, FIFO empty, count=0.
//   imem_pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
//  imem_pc is the pc register. Memory contract: valid rises once pc has been stable 1 cycle.
//  Capture (push) condition: imem_valid && !full && !redirect_valid.
//   On push: entry {pc, imem_instr} is written at tail, and pc <= pc+4 (mod 2^32, wraps silently).
//   Otherwise pc is held.
//   full = (count==FIFO_DEPTH). No same-cycle pop-to-make-room, to keep the out_ready->imem_pc path cut.
//  Pop: out_valid && out_ready. Head advances, and the pop counts the same cycle as a push (count unchanged).
//  out_valid = (count!=0); out_instr/out_pc show the head entry and are stable while out_valid && !out_ready.
//  Redirect (highest priority):
//   pc <= {redirect_pc[31:2],2'b00}; FIFO flushed (count=0, ptrs=0); imem response that cycle discarded.
//   A pop in the same cycle is ignored: decode must not consume on a redirect cycle.
//   out_valid goes to 0 the next cycle.
//  Redirect latency, redirect in cycle N:
//   N+1  imem_pc = target
//   N+2  earliest imem_valid/push
//   N+3  earliest out_valid
//  Back-to-back redirects: only the last one is taken. Redirect while full: flush still happens.
//  Steady state: 1 instr/cycle while imem_valid stays high and the FIFO is not full.
//  Mid-operation rst: all state returns to reset values immediately; in-flight response is dropped.
//  Invariant: 0 <= count <= FIFO_DEPTH. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
// CONFIGURATION
//  FETCH_PERF_EN defined adds two ports and counters:
//   perf_fetched  out  32  increments on each push
//   perf_stall    out  32  increments on each cycle with imem_valid && full
//   Both reset to 0 and wrap at 2^32; redirect does not clear them.
//  FETCH_PERF_EN undefined: the ports and counters do not exist; behaviour otherwise identical.
// STRUCTURE
//  Package fetch_pkg:
//   typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t
//   localparam INSTR_BYTES = 4
//   localparam NOP_INSTR = 32'h0000_0013
//  Sub-module fetch_fifo: sync FIFO of fetch_entry_t with FIFO_DEPTH, push/pop/flush and full/empty/count.
//  fetch_unit keeps the pc register, the push/redirect control and the optional perf counters.
// TESTING
//  1 Reset, RESET_PC=0, imem_valid high from cycle 2, out_ready=1
//    -> out_pc=0,4,8,12 on consecutive cycles; out_instr matches memory.
//  2 out_ready=0 with memory always valid -> exactly 4 pushes (pc 0..12), then imem_pc holds 16.
//    out_pc stays 0. Release out_ready -> stream resumes with 16 after 0..12.
//  3 Redirect to 32'h0000_0103 in cycle N with 3 entries buffered
//    -> imem_pc=0x100 at N+1; out_valid=0 at N+1 and N+2; first out_pc=0x100 at N+3.
//  4 Redirect in N (to 0x40) and N+1 (to 0x80) -> no 0x40 entry ever emitted; first out_pc=0x80.
//  5 rst pulsed mid-stream, between clock edges -> outputs reset asynchronously; fetch restarts at RESET_PC.
//  6 RESET_PC=32'hFFFF_FFFC, memory valid -> out_pc=0xFFFFFFFC then 0x00000000 (wrap).
//    With FETCH_PERF_EN: perf_fetched=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch block
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Force a byte address onto an instruction boundary
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch buffer of {pc, instr} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    // Guard the handshakes locally so count can never leave 0..DEPTH
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        head    = mem[rd_ptr];
    end

    // Pointers and occupancy; flush wins over any simultaneous push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage needs no reset: empty entries are never presented downstream
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch initiator with PC-tagged buffer; FETCH_PERF_EN adds perf counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    logic [31:0]  pc;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    // Push ignores pops in the same cycle so out_ready never reaches the pc path
    always_comb begin
        push           = imem_valid && !fifo_full && !redirect_valid;
        pop            = !fifo_empty && out_ready && !redirect_valid;
        wr_entry.pc    = pc;
        wr_entry.instr = imem_instr;
    end

    // Fetch address: redirect has priority, otherwise advance only on capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= align_pc(redirect_pc);
        end else if (push) begin
            pc <= pc + 32'(INSTR_BYTES);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head presentation; zeros while empty so stale storage never leaks out
    always_comb begin
        imem_pc   = pc;
        out_valid = !fifo_empty;
        out_instr = fifo_empty ? 32'h0 : head.instr;
        out_pc    = fifo_empty ? 32'h0 : head.pc;
    end

`ifdef FETCH_PERF_EN
    // Event counters survive redirects and wrap freely
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push)                    perf_fetched <= perf_fetched + 32'd1;
            if (imem_valid && fifo_full) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a queue model
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc, imem_instr, redirect_pc, out_instr, out_pc;
    logic        imem_valid, redirect_valid, out_valid, out_ready;
    logic [31:0] imem_pc2, imem_instr2, out_instr2, out_pc2;
    logic        imem_valid2, out_valid2;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        out_ready2 = 1'b1;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    assign imem_instr2 = mem_word(imem_pc2);

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .imem_valid(imem_valid), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .imem_pc(imem_pc2), .imem_instr(imem_instr2),
        .imem_valid(imem_valid2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2), .out_pc(out_pc2)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched2), .perf_stall(perf_stall2)
`endif
    );

    int total = 0;
    int bad = 0;

    fetch_entry_t mq[$];
    logic [31:0]  m_pc, m_prev_pc, m_fetched, m_stall;
    bit           m_has_prev;
    int           cyc2;
    int           seen2 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc       = 32'h0;
        m_prev_pc  = 32'h0;
        m_has_prev = 0;
        m_fetched  = 0;
        m_stall    = 0;
        cyc2       = 0;
    endtask

    // One cycle: compare outputs at negedge, drive inputs, advance the model past the next edge
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit mem_en);
        bit          mv;
        bit          was_full;
        logic [31:0] exp2;
        check_eq("imem_pc", imem_pc, m_pc);
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_eq("out_pc", out_pc, mq[0].pc);
            check_eq("out_instr", out_instr, mq[0].instr);
        end else begin
            check_eq("out_pc_idle", out_pc, 32'h0);
            check_eq("out_instr_idle", out_instr, 32'h0);
        end
`ifdef FETCH_PERF_EN
        check_eq("perf_fetched", perf_fetched, m_fetched);
        check_eq("perf_stall", perf_stall, m_stall);
`endif
        if (seen2 < 2 && out_valid2) begin
            exp2 = (seen2 == 0) ? 32'hFFFF_FFFC : 32'h0000_0000;
            check_eq("wrap_pc", out_pc2, exp2);
            check_eq("wrap_instr", out_instr2, mem_word(exp2));
`ifdef FETCH_PERF_EN
            if (seen2 == 1) check_eq("wrap_perf_fetched", perf_fetched2, 32'd2);
`endif
            seen2++;
        end

        // Memory answers once the address has settled or is streaming sequentially
        mv = mem_en && m_has_prev && (m_pc == m_prev_pc || m_pc == m_prev_pc + 32'd4);
        imem_valid     = mv;
        imem_instr     = mv ? mem_word(m_pc) : $urandom;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_valid2    = (cyc2 >= 1);

        was_full = (mq.size() == DEPTH);
        if (mv && was_full) m_stall++;
        m_prev_pc  = m_pc;
        m_has_prev = 1;
        if (redir) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (mv && !was_full) begin
                mq.push_back('{pc: m_prev_pc, instr: mem_word(m_prev_pc)});
                m_pc = m_prev_pc + 32'd4;
                m_fetched++;
            end
        end
        cyc2++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        imem_valid = 1'b0; imem_instr = 32'h0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_valid2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int rate;
        // Reset values
        sync_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_imem_pc", imem_pc, 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_out_instr", out_instr, 32'h0);
        check_eq("rst_wrap_imem_pc", imem_pc2, 32'hFFFF_FFFC);
        rst = 1'b0;

        // Streaming with decode always ready
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1);

        // Decode stalled: buffer fills with 0..12 and fetch holds at 16
        sync_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        check_eq("stall_imem_pc", imem_pc, 32'd16);
        check_eq("stall_head_pc", out_pc, 32'd0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1);

        // Redirect with three entries buffered
        step(0, 1, 32'h0000_0200, 1);
        guard = 0;
        while (mq.size() < 3 && guard < 20) begin
            step(0, 0, 0, 1);
            guard++;
        end
        check_eq("fill3", mq.size(), 3);
        step(1, 1, 32'h0000_0103, 1);
        check_eq("redir_n1_pc", imem_pc, 32'h100);
        check_eq("redir_n1_valid", 32'(out_valid), 32'h0);
        step(1, 0, 0, 1);
        check_eq("redir_n2_valid", 32'(out_valid), 32'h0);
        step(1, 0, 0, 1);
        check_eq("redir_n3_valid", 32'(out_valid), 32'h1);
        check_eq("redir_n3_pc", out_pc, 32'h100);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);

        // Back-to-back redirects: only the second target is fetched
        step(1, 1, 32'h40, 1);
        step(1, 1, 32'h80, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check_eq("b2b_first_pc", out_pc, 32'h80);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);

        // Asynchronous reset between clock edges
        imem_valid = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        m_prev_pc = m_pc;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_imem_pc", imem_pc, 32'h0);
        check_eq("arst_out_valid", 32'(out_valid), 32'h0);
        check_eq("arst_out_pc", out_pc, 32'h0);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);

        // Randomized traffic with varying decode back-pressure
        rate = 80;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) rate = $urandom_range(10, 100);
            step(($urandom % 100) < rate, ($urandom % 16) == 0,
                 $urandom % 4096, ($urandom % 5) != 0);
        end

        check_eq("wrap_seen", seen2, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
